// File: rtl/mby_gmm_pkg.sv
`default_nettype none
// ============================================================================
// Module : mby_gmm_pkg
// Desc   : Shared types and constants for the GCM dequeue scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package mby_gmm_pkg;

  localparam int MBY_MAX_NUM_MGP     = 8;
  localparam int MBY_GCM_DEQ_PORT_W  = 6;
  localparam int MBY_GCM_DEQ_CNT_W   = 8;
  localparam int MBY_GCM_DEQ_NUM_REQ = 2 * MBY_MAX_NUM_MGP + 1;
  localparam int MBY_GCM_DEQ_VP_REQ  = MBY_GCM_DEQ_NUM_REQ - 1;

  typedef struct packed {
    logic [MBY_GCM_DEQ_PORT_W-1:0] port;
    logic [MBY_GCM_DEQ_CNT_W-1:0]  cnt;
  } mby_gcm_deq_evt_t;

  // Requester numbering: left MGP i -> 2i, right MGP i -> 2i+1, VP last.
  function automatic int mby_gcm_left_req(input int mgp);
    return 2 * mgp;
  endfunction

  function automatic int mby_gcm_right_req(input int mgp);
    return 2 * mgp + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mby_gcm_deq_fifo.sv
`default_nettype none
// ============================================================================
// Module : mby_gcm_deq_fifo
// Desc   : DEPTH-entry flop FIFO holding dequeue events of one requester.
// Rev    : 1.0  initial release
// ============================================================================
module mby_gcm_deq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (c_AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mby_gcm_deque_sched.sv
`default_nettype none
// ============================================================================
// Module : mby_gcm_deque_sched
// Desc   : Round-robin merge of per-requester dequeue FIFOs into one output
//          register. Define MBY_GCM_DEQ_STATS_EN for drop/grant counters.
// Rev    : 1.0  initial release
// ============================================================================
module mby_gcm_deque_sched
  import mby_gmm_pkg::*;
#(
  parameter int NUM_REQ = MBY_GCM_DEQ_NUM_REQ,
  parameter int DEPTH   = 4,
  parameter int PORT_W  = MBY_GCM_DEQ_PORT_W,
  parameter int CNT_W   = MBY_GCM_DEQ_CNT_W,
  parameter int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      cclk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        deq_valid,
  input  logic [NUM_REQ*PORT_W-1:0] deq_port,
  input  logic [NUM_REQ*CNT_W-1:0]  deq_cnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REQ_W-1:0]          out_req,
  output logic [PORT_W-1:0]         out_port,
  output logic [CNT_W-1:0]          out_cnt,
  output logic [NUM_REQ-1:0]        ovf_sticky,
  input  logic [NUM_REQ-1:0]        ovf_clr
`ifdef MBY_GCM_DEQ_STATS_EN
  ,
  output logic [15:0]               drop_total,
  output logic [31:0]               grant_total
`endif
);

  localparam int c_EVT_W = PORT_W + CNT_W;

  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_drop;
  logic [c_EVT_W-1:0] w_dout [NUM_REQ];

  logic               w_load;
  logic               w_found;
  logic               w_grant;
  logic [REQ_W-1:0]   w_win;
  logic [REQ_W:0]     w_sum;

  logic               r_valid;
  logic [REQ_W-1:0]   r_req;
  logic [c_EVT_W-1:0] r_evt;
  logic [REQ_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_ovf;

  assign w_load  = ~r_valid | out_ready;
  assign w_grant = w_load & w_found;

  // A pop frees a slot in the same cycle, so a full FIFO being granted can still take a push.
  generate
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
      assign w_pop[r]  = w_grant && (w_win == REQ_W'(r));
      assign w_push[r] = deq_valid[r] & (~w_full[r] | w_pop[r]);
      assign w_drop[r] = deq_valid[r] & w_full[r] & ~w_pop[r];

      mby_gcm_deq_fifo #(
        .DEPTH (DEPTH),
        .W     (c_EVT_W)
      ) u_fifo (
        .clk     (cclk),
        .rst     (reset),
        .i_push  (w_push[r]),
        .i_pop   (w_pop[r]),
        .i_din   ({deq_port[r*PORT_W +: PORT_W], deq_cnt[r*CNT_W +: CNT_W]}),
        .o_dout  (w_dout[r]),
        .o_full  (w_full[r]),
        .o_empty (w_empty[r])
      );
    end
  endgenerate

  // Search starts at r_rr_ptr; empty flags are registered, so same-cycle pushes never win.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (REQ_W+1)'(i);
      if (w_sum >= (REQ_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (REQ_W+1)'(NUM_REQ);
      end
      if (!w_found && !w_empty[w_sum[REQ_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[REQ_W-1:0];
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_req    <= '0;
      r_evt    <= '0;
      r_rr_ptr <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_found;
      end
      if (w_grant) begin
        r_req    <= w_win;
        r_evt    <= w_dout[w_win];
        r_rr_ptr <= (w_win == REQ_W'(NUM_REQ - 1)) ? '0 : w_win + REQ_W'(1);
      end
      r_ovf <= (r_ovf & ~ovf_clr) | w_drop;
    end
  end

  assign out_valid  = r_valid;
  assign out_req    = r_req;
  assign out_port   = r_evt[c_EVT_W-1:CNT_W];
  assign out_cnt    = r_evt[CNT_W-1:0];
  assign ovf_sticky = r_ovf;

`ifdef MBY_GCM_DEQ_STATS_EN
  logic [15:0] r_drop_total;
  logic [31:0] r_grant_total;
  logic [16:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_total} + 17'($countones(w_drop));

  always_ff @(posedge cclk) begin
    if (reset) begin
      r_drop_total  <= '0;
      r_grant_total <= '0;
    end else begin
      r_drop_total <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_grant) begin
        r_grant_total <= r_grant_total + 32'd1;
      end
    end
  end

  assign drop_total  = r_drop_total;
  assign grant_total = r_grant_total;
`endif

endmodule
`default_nettype wire
